// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared helpers for the parametrised serial pattern detector.
//   - default parameter values
//   - op_e: per-cycle operation decoded from clear/load/x_valid
//   - len_mask(len): mask with bits [len-1:0] set (MASK_W wide)
//   - len_legal(len, max_len): 1 when 1 <= len <= max_len
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 8;

  // Widest pattern the mask helper supports; MAX_LEN must not exceed it.
  localparam int MASK_W = 32;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_SHIFT   = 2'd1,
    OP_LOAD    = 2'd2,
    OP_BADLOAD = 2'd3
  } op_e;

  function automatic logic [MASK_W-1:0] len_mask(input logic [31:0] len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (32'(i) < len) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic len_legal(input logic [31:0] len,
                                     input logic [31:0] max_len);
    return (len != 32'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   : clock, rising edge
//   clear : synchronous active-high reset
//   sclr  : synchronous clear (same effect as clear, lower priority only
//           in the sense that both zero the count)
//   inc   : increment request
//   q     : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         sclr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sclr)                    cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: Moore serial-pattern detector with a runtime-loadable
// pattern (1..MAX_LEN bits), overlap / non-overlap mode, valid-qualified
// input and a saturating match counter.
//   clk         : clock, rising edge
//   clear       : synchronous active-high reset, highest priority
//   x, x_valid  : serial input bit and its qualifier
//   overlap     : 1 = overlapping matches, 0 = flush history after a match
//   load        : load pat_in/len_in this cycle (x of that cycle discarded)
//   pat_in      : new pattern, bit len-1 received first, bit 0 last
//   len_in      : new pattern length
//   out         : registered match pulse
//   match_count : saturating match count
//   cfg_err     : one-cycle pulse on a load with illegal length
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN = DEF_MAX_LEN,
  parameter int                 LEN_W   = DEF_LEN_W,
  parameter int                 CNT_W   = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'('b1001),
  parameter int                 DEF_LEN = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               x,
  input  logic               x_valid,
  input  logic               overlap,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);

  // Configuration
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;

  // Stream state. Only the newest MAX_LEN-1 bits are stored: the oldest bit
  // of the MAX_LEN-bit history is shifted out on the next valid cycle before
  // it could take part in any compare, so keeping it buys nothing.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  logic out_q, out_d;
  logic cfg_err_q, cfg_err_d;

  logic cnt_inc, cnt_sclr;

  op_e                op;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic               hit;

  // Operation decode; load wins over x_valid, clear is handled in the
  // register processes.
  always_comb begin
    op = OP_IDLE;
    if (load) begin
      op = len_legal(32'(len_in), 32'(MAX_LEN)) ? OP_LOAD : OP_BADLOAD;
    end else if (x_valid) begin
      op = OP_SHIFT;
    end
  end

  // Candidate history if this bit is accepted, and the match test on it.
  // fill gating keeps zero-initialised history from matching patterns made
  // of zeros before len real bits have arrived.
  always_comb begin
    hist_n = {hist_q, x};
    fill_n = (fill_q == MAX_LEN_L) ? MAX_LEN_L : fill_q + 1'b1;
    hit    = (fill_n >= len_q) &&
             (((MASK_W'(hist_n ^ pat_q)) & len_mask(32'(len_q))) == '0);
  end

  always_comb begin
    pat_d     = pat_q;
    len_d     = len_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    out_d     = 1'b0;
    cfg_err_d = 1'b0;
    cnt_inc   = 1'b0;
    cnt_sclr  = 1'b0;
    case (op)
      OP_LOAD: begin
        pat_d    = pat_in;
        len_d    = len_in;
        hist_d   = '0;
        fill_d   = '0;
        cnt_sclr = 1'b1;
      end
      OP_BADLOAD: begin
        cfg_err_d = 1'b1;
      end
      OP_SHIFT: begin
        out_d   = hit;
        cnt_inc = hit;
        if (hit && !overlap) begin
          hist_d = '0;
          fill_d = '0;
        end else begin
          hist_d = hist_n[MAX_LEN-2:0];
          fill_d = fill_n;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      pat_q     <= DEF_PAT;
      len_q     <= DEF_LEN_L;
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      out_q     <= out_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .clear (clear),
    .sclr  (cnt_sclr),
    .inc   (cnt_inc),
    .q     (match_count)
  );

  assign out     = out_q;
  assign cfg_err = cfg_err_q;

endmodule
